// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma word-copy engine.
// Optional fill mode is enabled by defining MEM_DMA_FILL_EN.
package mem_dma_pkg;

  localparam int LENW_DEF = 16;
  localparam logic [3:0] WSTRB_FULL = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_dma.sv
// Word copy/fill DMA initiator over a 1-cycle-latency read port and a no-backpressure write port.
// Fill mode exists only when MEM_DMA_FILL_EN is defined; otherwise fill/pattern are ignored.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            start,
  input  logic [31:2]     src,
  input  logic [31:2]     dst,
  input  logic [LENW-1:0] len,
  input  logic            fill,
  input  logic [31:0]     pattern,
  output logic            busy,
  output logic            done,
  output logic            rready,
  output logic [31:2]     raddr,
  input  logic            rresp,
  input  logic [31:0]     rdata,
  output logic            wready,
  output logic [31:2]     waddr,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb
);

  state_t          r_state;
  logic [31:2]     r_src;
  logic [31:2]     r_dst;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_cnt;
  logic [LENW-1:0] r_ridx;
  logic            r_rd_out;

  logic            w_fill;
  logic [31:0]     w_pat;
  logic            w_run;
  logic            w_act;
  logic            w_last;
  logic            w_rd;
  logic            w_wr;

`ifdef MEM_DMA_FILL_EN
  logic        r_fill;
  logic [31:0] r_pat;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_fill <= 1'b0;
      r_pat  <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_fill <= fill;
      r_pat  <= pattern;
    end
  end

  assign w_fill = r_fill;
  assign w_pat  = r_pat;
`else
  logic w_unused_fill;

  assign w_unused_fill = ^{fill, pattern};
  assign w_fill        = 1'b0;
  assign w_pat         = '0;
`endif

  assign w_run  = (r_state == S_RUN);
  assign w_act  = w_run | (r_state == S_DRAIN);
  assign w_last = (r_cnt == r_len - LENW'(1));
  assign w_rd   = w_run & ~w_fill;

  // Copy writes are slaved to the read response; fill writes run freely.
  assign w_wr = w_fill ? w_run : (w_act & r_rd_out & rresp);

  assign busy   = w_act;
  assign done   = (r_state == S_FIN);
  assign rready = w_rd;
  assign raddr  = r_src + 30'(r_cnt);
  assign wready = w_wr;
  assign waddr  = r_dst + 30'(w_fill ? r_cnt : r_ridx);
  assign wdata  = w_fill ? w_pat : rdata;
  assign wstrb  = WSTRB_FULL;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state  <= S_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_ridx   <= '0;
      r_rd_out <= 1'b0;
    end else begin
      r_rd_out <= w_rd;
      if (w_rd) r_ridx <= r_cnt;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src   <= src;
            r_dst   <= dst;
            r_len   <= len;
            r_cnt   <= '0;
            r_state <= (len == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + LENW'(1);
          if (w_last) r_state <= w_fill ? S_FIN : S_DRAIN;
        end
        S_DRAIN: begin
          if (w_wr) r_state <= S_FIN;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: memory responder, sequential-copy reference model, directed and random transfers.
// Fill expectations follow MEM_DMA_FILL_EN.
module tb_mem_dma;
  import mem_dma_pkg::*;

  localparam int LW = 4;
`ifdef MEM_DMA_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          start = 1'b0;
  logic [31:2]   src = '0;
  logic [31:2]   dst = '0;
  logic [LW-1:0] len = '0;
  logic          fill = 1'b0;
  logic [31:0]   pattern = '0;
  logic          busy, done, rready, wready;
  logic [31:2]   raddr, waddr;
  logic          rresp = 1'b0;
  logic [31:0]   rdata = '0;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  bit spur = 1'b0;
  bit pend_n = 1'b0;
  logic [29:0] paddr_n = '0;
  logic [31:0] mem [bit [29:0]];

  mem_dma #(.LENW(LW)) u_dut (
    .clk(clk), .resetb(resetb), .start(start),
    .src(src), .dst(dst), .len(len),
    .fill(fill), .pattern(pattern),
    .busy(busy), .done(done),
    .rready(rready), .raddr(raddr),
    .rresp(rresp), .rdata(rdata),
    .wready(wready), .waddr(waddr),
    .wdata(wdata), .wstrb(wstrb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Writes land mid-cycle, so a read answered next cycle sees them.
  always @(negedge clk) begin
    if (wready) begin
      mem[waddr] = wdata;
      wr_cnt++;
    end
    pend_n  = rready;
    paddr_n = raddr;
  end

  always @(posedge clk) begin
    #1;
    rresp = pend_n | spur;
    rdata = pend_n ? rd(paddr_n) : $urandom;
  end

  task automatic xfer(input logic [29:0] s, input logic [29:0] d,
                      input int n, input bit f, input logic [31:0] p);
    logic [31:0] em [bit [29:0]];
    bit fe, er, ew;
    int last, idx;
    logic [29:0] a, b;
    em = mem;
    fe = f && FILL_ON;
    for (int i = 0; i < n; i++) begin
      a = d + 30'(i);
      b = s + 30'(i);
      em[a] = fe ? p : (em.exists(b) ? em[b] : 32'h0);
    end
    last = (n == 0) ? 1 : (fe ? n + 1 : n + 2);
    @(posedge clk); #1;
    src = s; dst = d; len = LW'(n);
    fill = f; pattern = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; fill = $urandom; pattern = $urandom;
    src = $urandom; dst = $urandom; len = $urandom;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      er = !fe && k <= n;
      ew = fe ? (k <= n) : (k >= 2 && k <= n + 1);
      chk("busy", busy, 64'(k < last));
      chk("done", done, 64'(k == last));
      chk("rready", rready, er);
      chk("wready", wready, ew);
      if (er) begin
        a = s + 30'(k - 1);
        chk("raddr", raddr, a);
      end
      if (ew) begin
        idx = fe ? k - 1 : k - 2;
        a = d + 30'(idx);
        chk("waddr", waddr, a);
        chk("wdata", wdata, em[a]);
        chk("wstrb", wstrb, 4'hF);
      end
    end
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    for (int i = 0; i < n; i++) begin
      a = d + 30'(i);
      chk("mem", rd(a), em[a]);
    end
  endtask

  task automatic reset_mid();
    int wc;
    logic [31:0] v0;
    for (int i = 0; i < 8; i++) begin
      mem[30'h300 + 30'(i)] = $urandom;
      mem[30'h380 + 30'(i)] = 32'h0;
    end
    v0 = rd(30'h300);
    wc = wr_cnt;
    @(posedge clk); #1;
    src = 30'h300; dst = 30'h380; len = LW'(8);
    fill = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; src = 30'h700; dst = 30'h780; len = LW'(2);
    @(negedge clk);
    chk("c2_busy", busy, 1);
    chk("c2_raddr", raddr, 30'h301);
    @(posedge clk); #1;
    start = 1'b0; resetb = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rready", rready, 0);
    chk("rst_wready", wready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetb = 1'b1; spur = 1'b1;
    @(negedge clk);
    chk("rel_wready", wready, 0);
    chk("rel_busy", busy, 0);
    @(posedge clk); #1;
    spur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_wready", wready, 0);
    end
    chk("rst_wcount", wr_cnt - wc, 1);
    chk("rst_mem0", rd(30'h380), v0);
    chk("rst_mem1", rd(30'h381), 0);
    chk("rst_mem2", rd(30'h780), 0);
  endtask

  initial begin
    logic [29:0] s, d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_rready", rready, 0);
    chk("init_wready", wready, 0);
    @(posedge clk); #1;
    resetb = 1'b1;

    for (int i = 0; i < 4; i++)
      mem[30'h100 + 30'(i)] = 32'(i + 1) * 32'h11;
    xfer(30'h100, 30'h200, 4, 1'b0, 32'h0);
    chk("basic0", rd(30'h200), 32'h11);
    chk("basic3", rd(30'h203), 32'h44);

    xfer(30'h500, 30'h600, 0, 1'b0, 32'h0);

    mem[30'h10] = 32'hA5;
    xfer(30'h10, 30'h11, 3, 1'b0, 32'h0);
    chk("ovl3", rd(30'h13), 32'hA5);

    mem[30'h3FFFFFFF] = 32'hCAFE0001;
    mem[30'h0] = 32'hCAFE0002;
    xfer(30'h3FFFFFFF, 30'h800, 2, 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) mem[30'h20 + 30'(i)] = $urandom;
    xfer(30'h20, 30'h40, 3, 1'b1, 32'hDEADBEEF);

    for (int i = 0; i < 15; i++) mem[30'h900 + 30'(i)] = $urandom;
    xfer(30'h900, 30'h3FFFFFF8, 15, 1'b0, 32'h0);

    @(posedge clk); #1;
    spur = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("spur_wready", wready, 0);
    end
    @(posedge clk); #1;
    spur = 1'b0;

    reset_mid();

    for (int i = 0; i < 32; i++) mem[30'h100 + 30'(i)] = $urandom;
    for (int t = 0; t < 12; t++) begin
      s = 30'h100 + 30'($urandom_range(0, 15));
      d = 30'h100 + 30'($urandom_range(0, 15));
      xfer(s, d, $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter LENW, default 16, meaning the width of the transfer length in 32-bit words.
REQ-002 SHALL have port clk, input, 1, meaning the system clock; all logic is on its rising edge.
REQ-003 SHALL have port resetb, input, 1, meaning the reset: asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, meaning a transfer request, sampled in IDLE only.
REQ-005 SHALL have ports src and dst, input, [31:2], meaning the source and destination word addresses, sampled with start.
REQ-006 SHALL have port len, input, [LENW-1:0], meaning the word count, sampled with start.
REQ-007 SHALL have ports fill (input, 1) and pattern (input, [31:0]), meaning fill-mode select and fill word, sampled with start.
REQ-008 SHALL have ports busy (output, 1) and done (output, 1), meaning transfer active and a 1-cycle completion pulse.
REQ-009 SHALL have read-port ports rready (output, 1), raddr (output, [31:2]), rresp (input, 1) and rdata (input, [31:0]).
REQ-010 SHALL have write-port ports wready (output, 1), waddr (output, [31:2]), wdata (output, [31:0]) and wstrb (output, [3:0]).

Function
REQ-011 SHALL act as the initiator of the memory read/write port.
- Read protocol: the responder returns rresp=1 with rdata exactly 1 cycle after rready=1.
- Write protocol: a write is accepted in the same cycle it is presented; there is no backpressure.
REQ-012 SHALL implement an FSM with states IDLE, RUN, DRAIN and FIN.
- FIN lasts one cycle, asserts done, then returns to IDLE.
REQ-013 SHALL, in IDLE with start=1:
- latch src, dst, len, fill and pattern;
- clear the word counter cnt;
- go to FIN if len==0 (no memory accesses are made), otherwise go to RUN.
REQ-014 SHALL, in RUN in copy mode, drive rready=1 with raddr=src+cnt each cycle and increment cnt.
- After the read for cnt==len-1 is issued, the FSM SHALL go to DRAIN.
REQ-015 SHALL present a write in the same cycle it observes rresp=1 for an outstanding read.
- wready=1, waddr=dst+k (k = index of that read), wdata=rdata, wstrb=4'hF.
- These outputs are combinational from rresp/rdata.
REQ-016 SHALL leave DRAIN for FIN in the cycle in which the last write is presented.
REQ-017 SHALL give a copy of N words the following timing, with start sampled at edge 0:
- reads in cycles 1..N;
- writes in cycles 2..N+1;
- done in cycle N+2;
- busy=1 in cycles 1..N+1.
REQ-018 SHALL make the memory contents after a copy equal a sequential ascending word-by-word copy, including overlapping ranges.
- This relies on the responder forwarding same-cycle write data to a read.
REQ-019 SHALL compute addresses modulo 2^30, so src+cnt and dst+k wrap silently with no error.
REQ-020 SHALL ignore start in every state other than IDLE.
REQ-021 SHALL ignore rresp when no read is outstanding, issuing no write.
REQ-022 SHALL drive rready=0 and wready=0 in IDLE and FIN.
- raddr, waddr and wdata are don't-care whenever the matching ready is 0.
REQ-023 SHALL accept len = 2^LENW-1 as the maximum length, with no counter overflow.

Reset
REQ-024 SHALL clear on resetb=0: state=IDLE, cnt=0, outstanding-read flag=0, busy=0, done=0, rready=0, wready=0.
REQ-025 SHALL abandon a transfer when reset is asserted mid-transfer.
- Writes already accepted remain in memory.
- No write is issued in the first cycle after reset release.

Configuration
REQ-026 SHALL support fill mode only when the macro MEM_DMA_FILL_EN is defined.
- Fill is selected by fill=1 at start.
- RUN issues no reads and writes pattern to dst+cnt, cnt=0..len-1, one word per cycle.
- Timing: writes in cycles 1..N, done in cycle N+1.
REQ-027 SHALL, without MEM_DMA_FILL_EN, ignore the fill and pattern ports and always perform a copy; the ports remain present.

Structure
REQ-028 SHALL place the FSM state enum, the LENW default and the constant WSTRB_FULL=4'hF in the shared package mem_dma_pkg.
REQ-029 SHALL be a single flat module; no sub-module is required.

Verification
REQ-030 SHALL cover a basic copy.
- Stimulus: src=0x100, dst=0x200, len=4, memory pre-loaded with 0x11..0x44.
- Required: words 0x200..0x203 = 0x11, 0x22, 0x33, 0x44; done in cycle 6; busy high in cycles 1..5.
REQ-031 SHALL cover a zero-length start.
- Stimulus: len=0.
- Required: no rready, no wready; done in cycle 1.
REQ-032 SHALL cover an overlapping forward copy.
- Stimulus: src=0x10, dst=0x11, len=3, mem[0x10]=0xA5.
- Required: words 0x11..0x13 = 0xA5.
REQ-033 SHALL cover address wrap.
- Stimulus: src=0x3FFFFFFF, len=2.
- Required: raddr sequence 0x3FFFFFFF, 0x00000000.
REQ-034 SHALL cover start while busy and reset mid-transfer.
- Stimulus: a second start pulse in cycle 2; reset in cycle 3 of a len=8 copy.
- Required: the second start is ignored; after reset, busy=0, done=0, no further writes.
REQ-035 SHALL cover fill mode, with MEM_DMA_FILL_EN defined.
- Stimulus: fill=1, pattern=0xDEADBEEF, dst=0x40, len=3.
- Required: three writes in cycles 1..3, no rready, done in cycle 4.
